dram_bus_responder: RTL and testbench

- Memory-side counterpart of the VIC-II bus master: behaves as the C64's multiplexed DRAM (plus optional colour RAM) on the same pins the chip drives.
- Samples `ras`/`cas`/`rw`, reassembles the 16-bit address from the multiplexed lines, serves reads onto the data bus and commits writes.
- Used on the bench board and in system simulation, so fetch sequences can run without a motherboard.

---
 rtl/dram_bus_responder_pkg.sv | 34 +++
 rtl/dram_bus_responder_bus_sync_edge.sv | 56 +++++
 rtl/dram_bus_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_dram_bus_responder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_bus_responder_pkg.sv
// Shared definitions for the DRAM bus responder.
// Holds the access FSM state type, the widths of the row/column address
// pieces that the bus multiplexes onto adl/adh/bank, the colour RAM
// address width and a helper that reassembles the 16-bit address.
// Optional feature macro used by the top: COLOR_RAM_EN.
package dram_bus_responder_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ROW,
      COL_RD,
      DRIVE,
      COL_WR,
      PRE
   } state_t;

   localparam int ROW_LO_W = 6;   // A5:A0 from adl at the RAS fall
   localparam int ROW_HI_W = 2;   // A7:A6 from adh[1:0] at the RAS fall
   localparam int COL_W    = 6;   // A13:A8 from adl at the CAS fall
   localparam int BANK_W   = 2;   // A15:A14 from the bank pins
   localparam int ADDR_W   = ROW_LO_W + ROW_HI_W + COL_W + BANK_W;
   localparam int COLOR_AW = 10;

   // Address layout, MSB first: bank | column | row high | row low.
   function automatic logic [ADDR_W-1:0] build_addr(
      input logic [BANK_W-1:0]   bank_bits,
      input logic [COL_W-1:0]    col_bits,
      input logic [ROW_HI_W-1:0] row_hi_bits,
      input logic [ROW_LO_W-1:0] row_lo_bits
   );
      return {bank_bits, col_bits, row_hi_bits, row_lo_bits};
   endfunction

endpackage

// File: rtl/dram_bus_responder_bus_sync_edge.sv
// bus_sync_edge: multi-flop synchroniser for an asynchronous bus vector,
// with single-cycle fall/rise strobes derived from bit 0 of the
// synchronised value (current sample vs previous sample).
// Ports:
//   clk_dot4x  sampling clock
//   rst_n      asynchronous active-low reset (flops load RST_VAL)
//   d          asynchronous input vector
//   q          synchronised vector (STAGES flops of latency)
//   fall, rise edge strobes for q[0]
module bus_sync_edge #(
   parameter int               WIDTH   = 1,
   parameter int               STAGES  = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_dot4x,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             fall,
   output logic             rise
);

   logic [WIDTH-1:0] chain [STAGES+1];
   logic             prev_reg;

   assign chain[0] = d;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES; gi++) begin : g_stage
         logic [WIDTH-1:0] stage_reg;
         always_ff @(posedge clk_dot4x or negedge rst_n) begin
            if (!rst_n) begin
               stage_reg <= RST_VAL;
            end else begin
               stage_reg <= chain[gi];
            end
         end
         assign chain[gi+1] = stage_reg;
      end
   endgenerate

   assign q = chain[STAGES];

   always_ff @(posedge clk_dot4x or negedge rst_n) begin
      if (!rst_n) begin
         prev_reg <= RST_VAL[0];
      end else begin
         prev_reg <= q[0];
      end
   end

   assign fall = prev_reg & ~q[0];
   assign rise = ~prev_reg & q[0];

endmodule

// File: rtl/dram_bus_responder.sv
// dram_bus_responder: behaves as the C64 multiplexed DRAM (and, with the
// COLOR_RAM_EN macro defined, the 1Kx4 colour RAM) on the VIC-II bus pins.
// The row address is latched on the RAS fall, the column on the CAS fall;
// reads are driven onto dbo until CAS rises, writes commit on the CAS rise.
// A RAS rise before the access completes abandons it.
// Ports:
//   clk_dot4x       sampling clock (the bus pins are asynchronous to it)
//   rst_n           asynchronous active-low reset
//   ras, cas        active-low strobes
//   rw              1 = read, 0 = write (taken at the CAS fall)
//   adl, adh, bank  multiplexed low lines, high lines, A15:A14
//   dbi             write data
//   dbo, dbo_oe     read data and its drive enable
//   busy            FSM not in IDLE
//   ce_color, dbh_o, dbh_oe   colour RAM select/data/enable (COLOR_RAM_EN)
module dram_bus_responder
   import dram_bus_responder_pkg::*;
#(
   parameter int MEM_AW      = 16,
   parameter int SYNC_STAGES = 2     // must be at least 2
) (
   input  logic       clk_dot4x,
   input  logic       rst_n,
   input  logic       ras,
   input  logic       cas,
   input  logic       rw,
   input  logic [5:0] adl,
   input  logic [5:0] adh,
   input  logic [1:0] bank,
   input  logic [7:0] dbi,
`ifdef COLOR_RAM_EN
   input  logic       ce_color,
   output logic [3:0] dbh_o,
   output logic       dbh_oe,
`endif
   output logic [7:0] dbo,
   output logic       dbo_oe,
   output logic       busy
);

   localparam int VEC_BASE_W = 1 + 6 + 6 + 8;
`ifdef COLOR_RAM_EN
   localparam int VEC_W = VEC_BASE_W + 1;
`else
   localparam int VEC_W = VEC_BASE_W;
`endif
   localparam int MEM_DEPTH = 1 << MEM_AW;

   logic             ras_s, ras_fall, ras_rise;
   logic             cas_s, cas_fall, cas_rise;
   logic [VEC_W-1:0] vec_d, vec_s;
   logic             vec_fall, vec_rise;
   logic             rw_s;
   logic [5:0]       adl_s, adh_s;
   logic [7:0]       dbi_s;
   logic             color_sel_now;
   logic             unused_bits;

   // Strobes idle high, so their synchronisers reset to 1 to avoid a
   // false fall right after reset.
   bus_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ras_sync (
      .clk_dot4x (clk_dot4x),
      .rst_n     (rst_n),
      .d         (ras),
      .q         (ras_s),
      .fall      (ras_fall),
      .rise      (ras_rise)
   );

   bus_sync_edge #(.WIDTH(1), .STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cas_sync (
      .clk_dot4x (clk_dot4x),
      .rst_n     (rst_n),
      .d         (cas),
      .q         (cas_s),
      .fall      (cas_fall),
      .rise      (cas_rise)
   );

   // Address/data/control share one synchroniser so they arrive aligned
   // with the strobes that qualify them.
`ifdef COLOR_RAM_EN
   assign vec_d         = {ce_color, rw, adh, adl, dbi};
   assign color_sel_now = ~vec_s[VEC_W-1];
`else
   assign vec_d         = {rw, adh, adl, dbi};
   assign color_sel_now = 1'b0;
`endif

   bus_sync_edge #(.WIDTH(VEC_W), .STAGES(SYNC_STAGES)) u_vec_sync (
      .clk_dot4x (clk_dot4x),
      .rst_n     (rst_n),
      .d         (vec_d),
      .q         (vec_s),
      .fall      (vec_fall),
      .rise      (vec_rise)
   );

   assign dbi_s = vec_s[7:0];
   assign adl_s = vec_s[13:8];
   assign adh_s = vec_s[19:14];
   assign rw_s  = vec_s[20];

   assign unused_bits = ^{adh_s[5:2], vec_fall, vec_rise, cas_s};

   state_t        state_reg, state_next;
   logic [15:0]   addr_reg, addr_next, col_addr;
   logic [9:0]    row_bits;
   logic          sel_color_reg, sel_color_next;
   logic          mem_re, mem_we, dbo_load, enter_col;
   logic [7:0]    dbo_reg, mem_rdata;

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      sel_color_next = sel_color_reg;
      mem_re         = 1'b0;
      mem_we         = 1'b0;
      dbo_load       = 1'b0;
      enter_col      = 1'b0;

      // Row part of the address: live pins when RAS and CAS fall together
      // in IDLE, otherwise the value latched at the RAS fall.
      if (state_reg == IDLE) begin
         row_bits = {bank, adh_s[1:0], adl_s};
      end else begin
         row_bits = {addr_reg[15:14], addr_reg[7:0]};
      end
      col_addr = build_addr(row_bits[9:8], adl_s, row_bits[7:6], row_bits[5:0]);

      case (state_reg)
         IDLE: begin
            if (ras_fall) begin
               if (cas_fall) begin
                  enter_col = 1'b1;
               end else begin
                  addr_next  = build_addr(bank, addr_reg[13:8], adh_s[1:0], adl_s);
                  state_next = ROW;
               end
            end
         end
         ROW: begin
            if (ras_rise) begin
               state_next = IDLE;          // RAS-only refresh
            end else if (cas_fall) begin
               enter_col = 1'b1;
            end
         end
         COL_RD: begin
            if (ras_rise) begin
               state_next = IDLE;
            end else begin
               state_next = DRIVE;
               dbo_load   = 1'b1;
            end
         end
         DRIVE: begin
            if (ras_rise) begin
               state_next = IDLE;
            end else if (cas_rise) begin
               state_next = PRE;
            end
         end
         COL_WR: begin
            // An abort (RAS rise) wins over a simultaneous CAS rise.
            if (ras_rise) begin
               state_next = IDLE;
            end else if (cas_rise) begin
               state_next = PRE;
               mem_we     = 1'b1;
            end
         end
         PRE: begin
            if (ras_s) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase

      if (enter_col) begin
         addr_next      = col_addr;
         sel_color_next = color_sel_now;
         mem_re         = rw_s;
         if (rw_s) begin
            state_next = COL_RD;
         end else begin
            state_next = COL_WR;
         end
      end
   end

   always_ff @(posedge clk_dot4x or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         sel_color_reg <= 1'b0;
         dbo_reg       <= 8'h00;
      end else begin
         state_reg     <= state_next;
         addr_reg      <= addr_next;
         sel_color_reg <= sel_color_next;
         if (dbo_load && !sel_color_reg) begin
            dbo_reg <= mem_rdata;
         end
      end
   end

   // Main DRAM: contents are deliberately not reset. High address bits
   // above MEM_AW are dropped, so upper addresses alias.
   logic [7:0] mem [MEM_DEPTH];

   always_ff @(posedge clk_dot4x) begin
      if (mem_we && !sel_color_reg) begin
         mem[addr_reg[MEM_AW-1:0]] <= dbi_s;
      end
      if (mem_re && !color_sel_now) begin
         mem_rdata <= mem[col_addr[MEM_AW-1:0]];
      end
   end

   // Drive enable decodes straight from the async-reset state register so
   // that reset releases the bus without waiting for a clock.
   assign dbo    = dbo_reg;
   assign dbo_oe = (state_reg == DRIVE) && !sel_color_reg;
   assign busy   = (state_reg != IDLE);

`ifdef COLOR_RAM_EN
   logic [3:0] cram [1 << COLOR_AW];
   logic [3:0] cram_rdata;
   logic [3:0] dbh_reg;

   always_ff @(posedge clk_dot4x) begin
      if (mem_we && sel_color_reg) begin
         cram[addr_reg[COLOR_AW-1:0]] <= dbi_s[3:0];
      end
      if (mem_re && color_sel_now) begin
         cram_rdata <= cram[col_addr[COLOR_AW-1:0]];
      end
   end

   always_ff @(posedge clk_dot4x or negedge rst_n) begin
      if (!rst_n) begin
         dbh_reg <= 4'h0;
      end else if (dbo_load && sel_color_reg) begin
         dbh_reg <= cram_rdata;
      end
   end

   assign dbh_o  = dbh_reg;
   assign dbh_oe = (state_reg == DRIVE) && sel_color_reg;
`endif

endmodule

// File: tb/tb_dram_bus_responder.sv
// Testbench for dram_bus_responder: random bus accesses against a
// byte-array model of the DRAM; read expectations go into a queue that a
// separate monitor pops whenever dbo_oe rises. Colour RAM checks are
// compiled only when COLOR_RAM_EN is defined.
module tb_dram_bus_responder;

   localparam int MEM_AW = 16;
   localparam int SYNC   = 2;

   logic       clk_dot4x = 1'b0;
   logic       rst_n     = 1'b1;
   logic       ras = 1'b1, cas = 1'b1, rw = 1'b1;
   logic [5:0] adl = '0, adh = '0;
   logic [1:0] bank = '0;
   logic [7:0] dbi = '0;
   logic [7:0] dbo;
   logic       dbo_oe, busy;
   logic       color_sel = 1'b0;
`ifdef COLOR_RAM_EN
   logic       ce_color;
   logic [3:0] dbh_o;
   logic       dbh_oe;
   assign ce_color = ~color_sel;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [7:0] data;
      int         due;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   int          rel_q[$];
   logic [7:0]  model_mem [int];
   logic [15:0] written[$];

   dram_bus_responder #(.MEM_AW(MEM_AW), .SYNC_STAGES(SYNC)) dut (
      .clk_dot4x (clk_dot4x),
      .rst_n     (rst_n),
      .ras       (ras),
      .cas       (cas),
      .rw        (rw),
      .adl       (adl),
      .adh       (adh),
      .bank      (bank),
      .dbi       (dbi),
`ifdef COLOR_RAM_EN
      .ce_color  (ce_color),
      .dbh_o     (dbh_o),
      .dbh_oe    (dbh_oe),
`endif
      .dbo       (dbo),
      .dbo_oe    (dbo_oe),
      .busy      (busy)
   );

   always #5 clk_dot4x = ~clk_dot4x;
   always @(posedge clk_dot4x) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int midx(input logic [15:0] a);
      logic [15:0] mask;
      mask = 16'((1 << MEM_AW) - 1);
      return int'(a & mask);
   endfunction

   // Move to 2 time units after the n-th following rising edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk_dot4x);
      #2;
   endtask

   // One complete access. simul drops RAS and CAS together, which needs
   // the column bits equal to the low row bits.
   task automatic access(input logic [15:0] a, input logic is_rd, input logic [7:0] wd,
                         input logic simul);
      ras  = 1'b0;
      adl  = a[5:0];
      adh  = {4'($urandom), a[7:6]};
      bank = a[15:14];
      if (!simul) begin
         step($urandom_range(1, 3));
         adl = a[13:8];
      end
      cas = 1'b0;
      rw  = is_rd;
      dbi = wd;
      if (is_rd && !color_sel) rd_q.push_back('{model_mem[midx(a)], cyc + SYNC + 2});
      step(1);
      rw  = 1'($urandom);            // must be ignored after the CAS fall
      adh = {4'($urandom), a[7:6]};
      step($urandom_range(4, 7));
      cas = 1'b1;
      if (is_rd && !color_sel) rel_q.push_back(cyc + SYNC + 1);
      step($urandom_range(1, 2));
      ras = 1'b1;
      if (!is_rd && !color_sel) model_mem[midx(a)] = wd;
      step(2);
      $display("access addr=%04h %s data=%02h simul=%0d color=%0d", a,
               is_rd ? "RD" : "WR", is_rd ? model_mem[midx(a)] : wd, simul, color_sel);
   endtask

   // Monitor: compare every drive window against the oldest expectation.
   initial begin : monitor
      logic    prev_oe;
      rd_exp_t e;
      int      due;
      prev_oe = 1'b0;
      forever begin
         @(negedge clk_dot4x);
         if (dbo_oe === 1'b1 && !prev_oe) begin
            if (rd_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_drive actual=dbo_oe=1 required=dbo_oe=0 (t=%0t)", $time);
            end else begin
               e = rd_q.pop_front();
               check("read_data", 32'(dbo), 32'(e.data));
               check("read_latency", 32'(cyc), 32'(e.due));
            end
         end else if (dbo_oe !== 1'b1 && prev_oe && rel_q.size() > 0) begin
            due = rel_q.pop_front();
            check("release_latency", 32'(cyc), 32'(due));
         end
         prev_oe = (dbo_oe === 1'b1);
      end
   end

   initial begin : stim
      logic [15:0] a;
      logic        simul;
      #1 rst_n = 1'b0;
      #1;
      check("reset_dbo", 32'(dbo), 32'h00);
      check("reset_dbo_oe", 32'(dbo_oe), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      step(2);
      rst_n = 1'b1;
      step(3);

      // Directed reads/writes, including the bank bits in the address.
      access(16'h1234, 1'b0, 8'hA5, 1'b0);
      access(16'h1234, 1'b1, 8'h00, 1'b0);
      access(16'hC0FF, 1'b0, 8'h3C, 1'b0);
      access(16'hC0FF, 1'b1, 8'h00, 1'b0);
      written.push_back(16'h1234);
      written.push_back(16'hC0FF);

      // Random fill, then a random mix of reads and writes.
      for (int i = 0; i < 60; i++) begin
         simul = ($urandom_range(0, 3) == 0);
         if (i < 20 || $urandom_range(0, 2) == 0 || written.size() == 0) begin
            a = 16'($urandom);
            if (simul) a[13:8] = a[5:0];
            access(a, 1'b0, 8'($urandom), simul);
            written.push_back(a);
         end else begin
            a = written[$urandom_range(0, written.size() - 1)];
            access(a, 1'b1, 8'h00, simul && (a[13:8] == a[5:0]));
         end
      end

      // RAS-only refresh: busy pulses, nothing driven, memory untouched.
      ras = 1'b0; adl = 6'h34; adh = 6'h00; bank = 2'b00;
      step(4);
      check("refresh_busy_high", 32'(busy), 32'h1);
      ras = 1'b1;
      step(5);
      check("refresh_busy_low", 32'(busy), 32'h0);
      $display("refresh done");
      access(16'h1234, 1'b1, 8'h00, 1'b0);

      // Abort: RAS rises one cycle after a write CAS fall.
      ras = 1'b0; adl = 6'h34; adh = 6'h00; bank = 2'b00;
      step(2);
      adl = 6'h12; rw = 1'b0; dbi = 8'h5A; cas = 1'b0;
      step(1);
      ras = 1'b1;
      step(1);
      cas = 1'b1;
      step(4);
      check("abort_idle", 32'(busy), 32'h0);
      $display("abort done");
      access(16'h1234, 1'b1, 8'h00, 1'b0);

      // Reset while driving.
      a = written[$urandom_range(0, written.size() - 1)];
      ras = 1'b0; adl = a[5:0]; adh = {4'h0, a[7:6]}; bank = a[15:14];
      step(1);
      adl = a[13:8]; rw = 1'b1; cas = 1'b0;
      rd_q.push_back('{model_mem[midx(a)], cyc + SYNC + 2});
      for (int i = 0; i < 12 && dbo_oe !== 1'b1; i++) @(negedge clk_dot4x);
      check("oe_before_reset", 32'(dbo_oe), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("reset_async_oe", 32'(dbo_oe), 32'h0);
      check("reset_async_busy", 32'(busy), 32'h0);
      cas = 1'b1; ras = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(3);
      $display("reset mid-read done");
      access(written[0], 1'b1, 8'h00, 1'b0);
      access(16'hC0FF, 1'b1, 8'h00, 1'b0);

`ifdef COLOR_RAM_EN
      access(16'h03FF, 1'b0, 8'h81, 1'b0);
      color_sel = 1'b1;
      access(16'h03FF, 1'b0, 8'hF7, 1'b0);
      access(16'h03FF, 1'b1, 8'h00, 1'b0);
      check("color_read", 32'(dbh_o), 32'h7);
      color_sel = 1'b0;
      access(16'h03FF, 1'b1, 8'h00, 1'b0);
`endif

      step(10);
      check("read_queue_drained", 32'(rd_q.size()), 32'h0);
      check("release_queue_drained", 32'(rel_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
